// File: rtl/mano_pkg.sv
// Shared constants and types for the Mano machine memory path.
// mem_ctrl and its bench both import this package.
package mano_pkg;

  localparam int AR_WIDTH   = 12;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int MEM_DEPTH  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR,
    ST_PTR_CAP,
    ST_ACCESS,
    ST_RD_CAP,
    ST_RESP
  } mc_state_e;

  // Effective address zero-extended onto the wider SRAM address port.
  function automatic logic [ADDR_WIDTH-1:0] to_mem_addr(input logic [AR_WIDTH-1:0] ea);
    return {{(ADDR_WIDTH-AR_WIDTH){1'b0}}, ea};
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-outstanding memory controller in front of the 4096x16 synchronous SRAM.
// Handles direct and pointer-indirect accesses and absorbs the SRAM read latency.
module mem_ctrl
  import mano_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_ind,
  input  logic [AR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [AR_WIDTH-1:0]   rsp_ea,
  output logic                  mem_we_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  mc_state_e             r_state;
  mc_state_e             w_next;
  logic                  r_we;
  logic [AR_WIDTH-1:0]   r_ea;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_mem_we_n;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  // NOTE: the default assignment first means every path assigns w_next, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (req_valid) w_next = req_ind ? ST_PTR : ST_ACCESS;
      ST_PTR:     w_next = ST_PTR_CAP;
      ST_PTR_CAP: w_next = ST_ACCESS;
      ST_ACCESS:  w_next = r_we ? ST_RESP : ST_RD_CAP;
      ST_RD_CAP:  w_next = ST_RESP;
      ST_RESP:    if (rsp_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Async reset pulls mem_we_n high at once, so an interrupted write never commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_ea        <= '0;
      r_rsp_rdata <= '0;
      r_mem_we_n  <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_ea        <= req_addr;
            r_mem_addr  <= to_mem_addr(req_addr);
            r_mem_wdata <= req_wdata;
            r_mem_we_n  <= req_ind | ~req_we;
          end
        end
        ST_PTR_CAP: begin
          r_ea       <= mem_rdata[AR_WIDTH-1:0];
          r_mem_addr <= to_mem_addr(mem_rdata[AR_WIDTH-1:0]);
          r_mem_we_n <= ~r_we;
        end
        ST_ACCESS: begin
          r_mem_we_n <= 1'b1;
          if (r_we) r_rsp_rdata <= '0;
        end
        ST_RD_CAP: r_rsp_rdata <= mem_rdata;
        default: r_mem_we_n <= 1'b1;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_ea    = r_ea;
  assign mem_we_n  = r_mem_we_n;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural 4096x16 registered-read SRAM.
// Table-driven transactions plus hand-written backpressure and reset-abort sequences.
module tb_mem_ctrl;
  import mano_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid, req_ready, req_we, req_ind;
  logic [AR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid, rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [AR_WIDTH-1:0]   rsp_ea;
  logic                  mem_we_n;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // SRAM model with a side preload port and a count of committed writes
  logic [DATA_WIDTH-1:0] sram [MEM_DEPTH];
  logic                  pl_en = 1'b0;
  logic [AR_WIDTH-1:0]   pl_addr = '0;
  logic [DATA_WIDTH-1:0] pl_data = '0;
  int                    wr_cnt = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (!mem_we_n) begin
      sram[mem_addr[AR_WIDTH-1:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= sram[mem_addr[AR_WIDTH-1:0]];
  end

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_ind(req_ind),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_ea(rsp_ea),
    .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string                 name;
    logic                  we;
    logic                  ind;
    logic [AR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] exp_rdata;
    logic [AR_WIDTH-1:0]   exp_ea;
    int                    exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request, measure latency, optionally stall the response, then retire it.
  task automatic run_txn(input vec_t v, input int hold);
    int lat;
    int wr0;
    wr0 = wr_cnt;
    @(negedge clk);
    check({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_ind = v.ind; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, " rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    check({v.name, " rsp_ea"}, 32'(rsp_ea), 32'(v.exp_ea));
    check({v.name, " mem_addr hi"}, 32'(mem_addr[ADDR_WIDTH-1:AR_WIDTH]), 32'd0);
    check({v.name, " req_ready busy"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({v.name, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({v.name, " hold rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
      check({v.name, " hold rsp_ea"}, 32'(rsp_ea), 32'(v.exp_ea));
      check({v.name, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, " retire rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({v.name, " retire req_ready"}, 32'(req_ready), 32'd1);
    check({v.name, " retire mem_we_n"}, 32'(mem_we_n), 32'd1);
    check({v.name, " sram writes"}, 32'(wr_cnt - wr0), v.we ? 32'd1 : 32'd0);
  endtask

  initial begin
    vec_t v;
    int   wr0;

    vecs[0] = '{"dir_wr_123",  1'b1, 1'b0, 12'h123, 16'hBEEF, 16'h0000, 12'h123, 2};
    vecs[1] = '{"dir_rd_123",  1'b0, 1'b0, 12'h123, 16'h0000, 16'hBEEF, 12'h123, 3};
    vecs[2] = '{"ind_rd_010",  1'b0, 1'b1, 12'h010, 16'h0000, 16'h1234, 12'h456, 5};
    vecs[3] = '{"ind_wr_020",  1'b1, 1'b1, 12'h020, 16'h5A5A, 16'h0000, 12'hABC, 4};
    vecs[4] = '{"dir_rd_ABC",  1'b0, 1'b0, 12'hABC, 16'h0000, 16'h5A5A, 12'hABC, 3};
    vecs[5] = '{"dir_rd_020",  1'b0, 1'b0, 12'h020, 16'h0000, 16'h0ABC, 12'h020, 3};
    vecs[6] = '{"dir_wr_FFF",  1'b1, 1'b0, 12'hFFF, 16'h8001, 16'h0000, 12'hFFF, 2};
    vecs[7] = '{"dir_rd_FFF",  1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h8001, 12'hFFF, 3};
    vecs[8] = '{"ind_rd_020b", 1'b0, 1'b1, 12'h020, 16'h0000, 16'h5A5A, 12'hABC, 5};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_ind = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #12;
    check("reset mem_we_n", 32'(mem_we_n), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset rsp_ea", 32'(rsp_ea), 32'd0);
    check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // rsp_ready high while idle must not disturb anything
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle rsp_ready req_ready", 32'(req_ready), 32'd1);
    check("idle rsp_ready rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    preload(12'h010, 16'hF456);
    preload(12'h456, 16'h1234);
    preload(12'h020, 16'h0ABC);

    for (int i = 0; i < 9; i++) run_txn(vecs[i], 0);
    check("sram ABC", 32'(sram[12'hABC]), 32'h5A5A);
    check("sram 020", 32'(sram[12'h020]), 32'h0ABC);

    // Backpressure: response held for 6 cycles
    v = '{"bp_rd_123", 1'b0, 1'b0, 12'h123, 16'h0000, 16'hBEEF, 12'h123, 3};
    run_txn(v, 6);

    // Reset during the ACCESS cycle of a write: no commit
    preload(12'h055, 16'h2222);
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_ind = 1'b0; req_addr = 12'h055; req_wdata = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort mem_we_n in access", 32'(mem_we_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort mem_we_n async", 32'(mem_we_n), 32'd1);
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort sram 055", 32'(sram[12'h055]), 32'h2222);
    check("abort sram writes", 32'(wr_cnt - wr0), 32'd0);
    v = '{"rd_055_after_abort", 1'b0, 1'b0, 12'h055, 16'h0000, 16'h2222, 12'h055, 3};
    run_txn(v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory access controller sitting directly upstream of the 4096x16 synchronous SRAM in the Mano machine datapath. Accepts one CPU memory request at a time over a valid/ready handshake. Drives the SRAM's active-low write enable, 16-bit address and write data, and absorbs the SRAM's one-cycle registered read latency. Supports Mano indirect addressing: a pointer fetch from M[addr] supplies the 12-bit effective address for the real access.

Parameters:
AR_WIDTH, 12, CPU address width (Mano AR); zero-extended onto mem_addr
ADDR_WIDTH, 16, SRAM address port width
DATA_WIDTH, 16, word width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller accepts a request this cycle
req_we  in  1  1 = write, 0 = read
req_ind  in  1  1 = indirect: effective address = M[req_addr][AR_WIDTH-1:0]
req_addr  in  AR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response/completion present
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_ea  out  AR_WIDTH  effective address actually accessed
mem_we_n  out  1  SRAM write enable, active low
mem_addr  out  ADDR_WIDTH  SRAM address, {zeros, ea}
mem_wdata  out  DATA_WIDTH  SRAM write data
mem_rdata  in  DATA_WIDTH  SRAM registered read data, valid one edge after mem_addr is presented

Behaviour:
- Reset (async, immediate): state=IDLE, mem_we_n=1, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_ea=0. req_ready=1 once in IDLE.
- All mem_* outputs are registered. mem_we_n=0 only while state=ACCESS and the latched op is a write.
- States: IDLE, PTR (pointer address on bus), PTR_CAP (capture pointer), ACCESS, RD_CAP, RESP.
- IDLE: req_ready=1. On req_valid at edge E0, latch we/wdata/ind. Set mem_addr=req_addr. Next state: PTR if ind, else ACCESS.
- PTR: mem_we_n=1. At the edge the SRAM registers M[addr]; go PTR_CAP.
- PTR_CAP: at the edge set ea=mem_rdata[AR_WIDTH-1:0], mem_addr={0,ea}, mem_wdata=wdata; go ACCESS.
- ACCESS: write completes at this edge; go RESP with rsp_rdata=0. For a read the SRAM registers M[ea] at this edge; go RD_CAP.
- RD_CAP: capture rsp_rdata=mem_rdata; go RESP.
- RESP: rsp_valid=1, rsp_ea=ea; all held stable until rsp_ready. On rsp_valid&rsp_ready go IDLE with mem_we_n=1. No new request is accepted in the same cycle.
- Latency from acceptance edge to rsp_valid high: direct write 2, direct read 3, indirect write 4, indirect read 5 cycles.
- One outstanding transaction; req_ready=0 in every state except IDLE.
- Read-after-write to the same address is always correct: operations are serialized, and a write commits before the next request is accepted.
- Indirect pointer uses only the low AR_WIDTH bits; the upper pointer bits are ignored.
- Address range is 0..4095 with no wrap logic needed; mem_addr[15:12] is always 0.
- rst asserted mid-transaction: abort, return to IDLE. mem_we_n goes to 1 asynchronously, so no partial write occurs after reset assertion. The response is dropped.
- rsp_ready held high in IDLE has no effect.

Decomposition:
- Shared package mano_pkg: AR_WIDTH, word width, SRAM depth 4096, state enum for mem_ctrl.
- No sub-module; a single FSM plus its datapath registers.
- The bench instantiates mem_ctrl with the existing SRAM.

Test Plan:
- Reset then idle: rst pulse -> mem_we_n=1, rsp_valid=0, req_ready=1, mem_addr=0.
- Direct write/read: write 0xBEEF to 0x123 -> rsp_valid 2 cycles after acceptance, rsp_ea=0x123, mem_we_n low exactly one cycle. Read 0x123 -> rsp_rdata=0xBEEF, rsp_valid 3 cycles after acceptance.
- Indirect read: preload M[0x010]=0xF456, M[0x456]=0x1234; indirect read 0x010 -> rsp_ea=0x456, rsp_rdata=0x1234, latency 5. The upper pointer nibble 0xF is ignored.
- Indirect write: M[0x020]=0x0ABC; indirect write 0x5A5A at 0x020 -> M[0xABC]=0x5A5A, M[0x020] unchanged, latency 4.
- Backpressure: hold rsp_ready=0 for 6 cycles after a read -> rsp_valid/rsp_rdata/rsp_ea stable, req_ready=0, no extra SRAM writes. Release -> IDLE next cycle.
- Reset mid-write: assert rst during ACCESS of a write of 0x1111 to 0x055 (old value 0x2222) -> mem_we_n=1 immediately, FSM in IDLE, M[0x055] remains 0x2222 when rst is asserted before the ACCESS edge.
